// File: rtl/svpwm_scheduler.sv
// Sequences the SVPWM datapath: centre-aligned carrier, double-buffered duty
// triplets applied at the valley, and dead-time gate drive with sticky fault.
module svpwm_scheduler #(
  parameter int WIDTH    = 8,
  parameter int CNT_MAX  = 255,
  parameter int DEADTIME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fault,
  input  logic             fault_clr,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic [WIDTH-1:0] da_on,
  input  logic [WIDTH-1:0] db_on,
  input  logic [WIDTH-1:0] dc_on,
  output logic             sample_req,
  output logic             update,
  output logic [WIDTH-1:0] cnt,
  output logic             gate_ah,
  output logic             gate_al,
  output logic             gate_bh,
  output logic             gate_bl,
  output logic             gate_ch,
  output logic             gate_cl,
  output logic             in_fault
);
  localparam int DT_W = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [WIDTH-1:0] PEAK = WIDTH'(CNT_MAX);
  localparam logic [DT_W-1:0] DT_LOAD = (DEADTIME == 0) ? '0 : DT_W'(DEADTIME - 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t           state;
  logic             dir_down;
  logic             pend_full;
  logic             upd_r;
  logic [WIDTH-1:0] duty_in [3];
  logic [WIDTH-1:0] pend [3];
  logic [WIDTH-1:0] act [3];
  logic [2:0]       ref_p1;
  logic [2:0]       ref_p2;
  logic [2:0]       gh;
  logic [2:0]       gl;
  logic [DT_W-1:0]  dt [3];
  logic             xfer;
  logic             valley;
  logic             run_next;

  assign duty_in[0] = da_on;
  assign duty_in[1] = db_on;
  assign duty_in[2] = dc_on;

  assign duty_ready = !rst && !pend_full && (state != FAULT);
  assign xfer       = duty_valid && duty_ready;
  assign valley     = (state == RUN) && (cnt == '0);
  assign sample_req = valley;
  assign update     = upd_r;
  assign in_fault   = (state == FAULT);
  assign run_next   = (state == RUN) && en && !fault;

  assign gate_ah = gh[0];
  assign gate_al = gl[0];
  assign gate_bh = gh[1];
  assign gate_bl = gl[1];
  assign gate_ch = gh[2];
  assign gate_cl = gl[2];

  // Stage p0: control FSM, carrier and duty double buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_down  <= 1'b0;
      pend_full <= 1'b0;
      upd_r     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        act[i]  <= '0;
        pend[i] <= '0;
      end
    end else begin
      upd_r <= 1'b0;
      if (fault) begin
        state     <= FAULT;
        cnt       <= '0;
        dir_down  <= 1'b0;
        pend_full <= 1'b0;
        for (int i = 0; i < 3; i++) act[i] <= '0;
      end else begin
        // The handshake blocks transfers while pending is full, so these never collide.
        if (valley && pend_full) begin
          for (int i = 0; i < 3; i++) act[i] <= pend[i];
          pend_full <= 1'b0;
          upd_r     <= 1'b1;
        end else if (xfer) begin
          for (int i = 0; i < 3; i++) pend[i] <= duty_in[i];
          pend_full <= 1'b1;
        end
        case (state)
          IDLE: if (en) state <= RUN;
          RUN: begin
            if (!en) begin
              state    <= IDLE;
              cnt      <= '0;
              dir_down <= 1'b0;
            end else if (!dir_down) begin
              if (cnt == PEAK) begin
                cnt      <= PEAK - WIDTH'(1);
                dir_down <= 1'b1;
              end else begin
                cnt <= cnt + WIDTH'(1);
              end
            end else if (cnt == '0) begin
              cnt      <= WIDTH'(1);
              dir_down <= 1'b0;
            end else begin
              cnt <= cnt - WIDTH'(1);
            end
          end
          FAULT: if (fault_clr) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage p1: carrier compare; stage p2: edge detect and dead-time gate drive
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ref_p1[i] <= 1'b0;
        ref_p2[i] <= 1'b0;
        gh[i]     <= 1'b0;
        gl[i]     <= 1'b0;
        dt[i]     <= '0;
      end else begin
        ref_p1[i] <= (state == RUN) && (act[i] > cnt);
        ref_p2[i] <= ref_p1[i];
        if (!run_next) begin
          gh[i] <= 1'b0;
          gl[i] <= 1'b0;
          dt[i] <= '0;
        end else if (ref_p1[i] != ref_p2[i]) begin
          // An edge always (re)starts the blanking window with the new reference.
          if (DEADTIME == 0) begin
            gh[i] <= ref_p1[i];
            gl[i] <= !ref_p1[i];
          end else begin
            gh[i] <= 1'b0;
            gl[i] <= 1'b0;
            dt[i] <= DT_LOAD;
          end
        end else if (dt[i] != '0) begin
          gh[i] <= 1'b0;
          gl[i] <= 1'b0;
          dt[i] <= dt[i] - DT_W'(1);
        end else begin
          gh[i] <= ref_p1[i];
          gl[i] <= !ref_p1[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_svpwm_scheduler.sv
// Directed testbench for svpwm_scheduler (WIDTH=8, CNT_MAX=255, DEADTIME=4).
module tb_svpwm_scheduler;
  logic       clk;
  logic       rst, en, fault, fault_clr, duty_valid, duty_ready;
  logic [7:0] da_on, db_on, dc_on, cnt;
  logic       sample_req, update, in_fault;
  logic       gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
  int         checks, errors, overlap;

  svpwm_scheduler #(.WIDTH(8), .CNT_MAX(255), .DEADTIME(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fault(fault), .fault_clr(fault_clr),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .da_on(da_on), .db_on(db_on), .dc_on(dc_on),
    .sample_req(sample_req), .update(update), .cnt(cnt),
    .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh),
    .gate_bl(gate_bl), .gate_ch(gate_ch), .gate_cl(gate_cl),
    .in_fault(in_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shoot-through watch on every leg for the whole run.
  always @(negedge clk)
    if (((gate_ah & gate_al) | (gate_bh & gate_bl) | (gate_ch & gate_cl)) === 1'b1)
      overlap++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; en = 0; fault = 0; fault_clr = 0; duty_valid = 0;
    da_on = 0; db_on = 0; dc_on = 0;
    repeat (3) tick();
    checks++; if ({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl} !== 6'b0) begin
      errors++; $display("FAIL reset_gates: got %b want 000000",
                         {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}); end
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL reset_sample_req: got %b want 0", sample_req); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b want 0", update); end
    checks++; if (in_fault !== 1'b0) begin errors++; $display("FAIL reset_in_fault: got %b want 0", in_fault); end
    checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", duty_ready); end
    rst = 0;
    #1;
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b want 1", duty_ready); end
    tick();
  endtask

  task automatic test_run();
    int k, nah, nbh, nch, nsr;
    logic upd1;
    duty_valid = 1; da_on = 128; db_on = 64; dc_on = 192;
    tick();
    duty_valid = 0;
    checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL preload_held: ready got %b want 0", duty_ready); end
    en = 1;
    tick();
    checks++; if ({sample_req, cnt} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL first_valley: sample_req=%b cnt=%0d want 1/0", sample_req, cnt); end
    upd1 = 0; k = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (i == 1) upd1 = update;
      if (sample_req === 1'b1) begin k = i; break; end
    end
    checks++; if (upd1 !== 1'b1) begin errors++; $display("FAIL update_after_valley: got %b want 1", upd1); end
    checks++; if (k != 510) begin errors++; $display("FAIL sample_period: got %0d want 510", k); end
    nah = 0; nbh = 0; nch = 0; nsr = 0;
    for (int i = 0; i < 510; i++) begin
      nah += int'(gate_ah); nbh += int'(gate_bh); nch += int'(gate_ch); nsr += int'(sample_req);
      tick();
    end
    checks++; if (nah != 251) begin errors++; $display("FAIL high_time_a: got %0d want 251", nah); end
    checks++; if (nbh != 123) begin errors++; $display("FAIL high_time_b: got %0d want 123", nbh); end
    checks++; if (nch != 379) begin errors++; $display("FAIL high_time_c: got %0d want 379", nch); end
    checks++; if (nsr != 1) begin errors++; $display("FAIL sample_per_period: got %0d want 1", nsr); end
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL next_valley: got %b want 1", sample_req); end
  endtask

  task automatic test_back_to_back();
    logic found, prev_sr, prev;
    int edge_cnt;
    repeat (100) tick();
    checks++; if (cnt !== 8'd100) begin errors++; $display("FAIL mid_period_cnt: got %0d want 100", cnt); end
    duty_valid = 1; da_on = 50; db_on = 60; dc_on = 70;
    tick();
    da_on = 10; db_on = 20; dc_on = 30;
    checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL second_stalled: ready got %b want 0", duty_ready); end
    found = 0; prev_sr = 0;
    for (int i = 0; i < 600; i++) begin
      prev_sr = sample_req;
      tick();
      if (duty_ready === 1'b1) begin found = 1; break; end
    end
    checks++; if ({found, prev_sr, update} !== 3'b111) begin
      errors++; $display("FAIL ready_after_valley: found/prev_valley/update got %b want 111", {found, prev_sr, update}); end
    tick();
    duty_valid = 0;
    checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL second_accepted: ready got %b want 0", duty_ready); end
    edge_cnt = -1;
    for (int i = 0; i < 600; i++) begin
      prev = gate_ah; tick();
      if (!prev && gate_ah) begin edge_cnt = int'(cnt); break; end
    end
    checks++; if (edge_cnt != 43) begin errors++; $display("FAIL first_duty_edge: ah rise at cnt %0d want 43", edge_cnt); end
    found = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (update === 1'b1) begin found = 1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL second_update: got %b want 1", found); end
    edge_cnt = -1;
    for (int i = 0; i < 600; i++) begin
      prev = gate_ah; tick();
      if (!prev && gate_ah) begin edge_cnt = int'(cnt); break; end
    end
    checks++; if (edge_cnt != 3) begin errors++; $display("FAIL second_duty_edge: ah rise at cnt %0d want 3", edge_cnt); end
  endtask

  task automatic test_deadtime();
    int gaps, bad, gap;
    logic seen, last_h, rdy;
    gaps = 0; bad = 0; gap = 0; seen = 0; last_h = 0;
    duty_valid = 1; da_on = 200; db_on = 128; dc_on = 128;
    for (int i = 0; i < 1600; i++) begin
      if (gate_ah || gate_al) begin
        if (seen && gap > 0) begin
          gaps++;
          if (gap != 4 || gate_ah == last_h) bad++;
        end
        seen = 1; gap = 0; last_h = gate_ah;
      end else begin
        gap++;
      end
      rdy = duty_ready;
      tick();
      if (rdy) da_on = (da_on == 8'd200) ? 8'd10 : 8'd200;
    end
    duty_valid = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL deadtime_gaps: %0d bad of %0d, want 0 bad", bad, gaps); end
    checks++; if (gaps < 4) begin errors++; $display("FAIL deadtime_count: got %0d transitions want >=4", gaps); end
  endtask

  task automatic test_fault();
    logic found;
    int nh, nupd;
    found = 0;
    for (int i = 0; i < 600; i++) begin
      if (cnt === 8'd100) begin found = 1; break; end
      tick();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL fault_reach_100: got %b want 1", found); end
    fault = 1;
    tick();
    checks++; if ({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl} !== 6'b0) begin
      errors++; $display("FAIL fault_gates: got %b want 000000",
                         {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}); end
    checks++; if ({in_fault, duty_ready} !== 2'b10) begin
      errors++; $display("FAIL fault_flags: in_fault/ready got %b want 10", {in_fault, duty_ready}); end
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL fault_cnt: got %0d want 0", cnt); end
    fault_clr = 1;
    tick();
    checks++; if (in_fault !== 1'b1) begin errors++; $display("FAIL fault_clr_ignored: got %b want 1", in_fault); end
    fault = 0;
    tick();
    checks++; if ({in_fault, duty_ready} !== 2'b01) begin
      errors++; $display("FAIL fault_cleared: in_fault/ready got %b want 01", {in_fault, duty_ready}); end
    fault_clr = 0;
    tick();
    checks++; if ({sample_req, cnt} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL restart_valley: sample_req=%b cnt=%0d want 1/0", sample_req, cnt); end
    nh = 0; nupd = 0;
    for (int i = 0; i < 520; i++) begin
      tick();
      nh += int'(gate_ah | gate_bh | gate_ch); nupd += int'(update);
    end
    checks++; if (nh != 0 || nupd != 0) begin
      errors++; $display("FAIL active_zero: high cycles %0d updates %0d want 0/0", nh, nupd); end
    checks++; if (gate_al !== 1'b1) begin errors++; $display("FAIL low_side_on: got %b want 1", gate_al); end
  endtask

  task automatic test_edge();
    logic f1, f2, f3;
    int al_low, bh_low, bl_hi;
    duty_valid = 1; da_on = 0; db_on = 255; dc_on = 128;
    tick();
    duty_valid = 0;
    f1 = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (update === 1'b1) begin f1 = 1; break; end
    end
    f2 = 0;
    for (int i = 0; i < 600; i++) begin
      if (cnt === 8'd255) begin f2 = 1; break; end
      tick();
    end
    checks++; if ({f1, f2} !== 2'b11) begin errors++; $display("FAIL edge_sync: update/peak got %b want 11", {f1, f2}); end
    al_low = 0; bh_low = 0; bl_hi = 0;
    for (int i = 0; i < 510; i++) begin
      al_low += int'(!gate_al); bh_low += int'(!gate_bh); bl_hi += int'(gate_bl);
      tick();
    end
    checks++; if (al_low != 0) begin errors++; $display("FAIL zero_duty_al: low cycles %0d want 0", al_low); end
    checks++; if (bh_low != 5) begin errors++; $display("FAIL full_duty_bh: low cycles %0d want 5", bh_low); end
    checks++; if (bl_hi != 0) begin errors++; $display("FAIL full_duty_bl: high cycles %0d want 0", bl_hi); end
    f3 = 0;
    for (int i = 0; i < 600; i++) begin
      if (cnt === 8'd100) begin f3 = 1; break; end
      tick();
    end
    en = 0;
    tick();
    checks++; if ({f3, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, sample_req} !== 8'b1000_0000
                  || cnt !== 8'd0) begin
      errors++; $display("FAIL en_drop: found/gates/sample_req got %b cnt %0d want 10000000 cnt 0",
                         {f3, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, sample_req}, cnt); end
  endtask

  task automatic test_no_overlap();
    checks++; if (overlap != 0) begin errors++; $display("FAIL no_shoot_through: %0d overlap cycles want 0", overlap); end
  endtask

  initial begin
    checks = 0; errors = 0; overlap = 0;
    test_reset();
    test_run();
    test_back_to_back();
    test_deadtime();
    test_fault();
    test_edge();
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
